// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants, coordinate type and line-phase decode
package vga_pkg;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;

  localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef logic [9:0] coord_t;

  typedef enum logic [1:0] {ACTIVE, FP, SYNC, BP} phase_e;

  // Same four-phase split serves both axes; only the boundaries differ.
  function automatic phase_e phase_of(coord_t c, int vis, int fp, int sync);
    if (int'(c) < vis)                  return ACTIVE;
    else if (int'(c) < vis + fp)        return FP;
    else if (int'(c) < vis + fp + sync) return SYNC;
    else                                return BP;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster outputs from the timing generator to the mappers and pins
interface vga_timing_gen_if;
  import vga_pkg::*;

  coord_t      DrawX;
  coord_t      DrawY;
  logic        blank;
  logic        hs;
  logic        vs;
  logic        vblank_start;
  logic [15:0] frame_count;

  modport master (output DrawX, DrawY, blank, hs, vs, vblank_start, frame_count);
  modport slave  (input  DrawX, DrawY, blank, hs, vs, vblank_start, frame_count);
endinterface

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - fixed-depth shift register with async active-low reset to a preset value
module vga_delay_line #(
  parameter int               WIDTH     = 2,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VAL;
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 raster counters, registered blank/sync and vblank pulse
// Optional macro VGA_SYNC_DELAY_EN delays hs/vs by PIPE_DELAY cycles.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE  = DEF_H_VISIBLE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_VISIBLE  = DEF_V_VISIBLE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int PIPE_DELAY = 2
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  vga_timing_gen_if.master vga
);

  localparam int H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;

  coord_t      hc_q, vc_q, hc_next, vc_next;
  logic        running_q;
  logic        blank_q, hs_raw_q, vs_raw_q, vblank_q, vblank_next;
  logic [15:0] fc_q, fc_next;
  phase_e      h_phase, v_phase;

  // The first edge out of reset holds (0,0) so the opening cycle shows pixel 0 as active.
  always_comb begin
    hc_next = hc_q;
    vc_next = vc_q;
    if (running_q) begin
      if (hc_q == coord_t'(H_TOT - 1)) begin
        hc_next = '0;
        if (vc_q == coord_t'(V_TOT - 1)) vc_next = '0;
        else                             vc_next = vc_q + coord_t'(1);
      end else begin
        hc_next = hc_q + coord_t'(1);
      end
    end
    h_phase     = phase_of(hc_next, H_VISIBLE, H_FP, H_SYNC);
    v_phase     = phase_of(vc_next, V_VISIBLE, V_FP, V_SYNC);
    vblank_next = (hc_next == '0) && (vc_next == coord_t'(V_VISIBLE));
    fc_next     = fc_q + (vblank_next ? 16'd1 : 16'd0);
  end

  // Flags are decoded from the next counter values so they line up with DrawX/DrawY.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      running_q <= 1'b0;
      hc_q      <= '0;
      vc_q      <= '0;
      fc_q      <= '0;
      blank_q   <= 1'b0;
      hs_raw_q  <= 1'b1;
      vs_raw_q  <= 1'b1;
      vblank_q  <= 1'b0;
    end else begin
      running_q <= 1'b1;
      hc_q      <= hc_next;
      vc_q      <= vc_next;
      fc_q      <= fc_next;
      blank_q   <= (h_phase == ACTIVE) && (v_phase == ACTIVE);
      hs_raw_q  <= (h_phase != SYNC);
      vs_raw_q  <= (v_phase != SYNC);
      vblank_q  <= vblank_next;
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  logic [1:0] sync_dly;

  vga_delay_line #(
    .WIDTH     (2),
    .DEPTH     (PIPE_DELAY),
    .RESET_VAL (2'b11)
  ) u_sync_dly (
    .clk   (vga_clk),
    .rst_n (reset_n),
    .din   ({vs_raw_q, hs_raw_q}),
    .dout  (sync_dly)
  );

  assign vga.hs = sync_dly[0];
  assign vga.vs = sync_dly[1];
`else
  logic unused_pipe_delay;
  assign unused_pipe_delay = ^PIPE_DELAY;
  assign vga.hs = hs_raw_q;
  assign vga.vs = vs_raw_q;
`endif

  assign vga.DrawX        = hc_q;
  assign vga.DrawY        = vc_q;
  assign vga.blank        = blank_q;
  assign vga.vblank_start = vblank_q;
  assign vga.frame_count  = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen against a raster-position model
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int LINE    = 800;
  localparam int FRAME   = 420000;
  localparam int VBL_POS = 480 * LINE;
`ifdef VGA_SYNC_DELAY_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif

  logic vga_clk = 1'b0;
  logic reset_n = 1'b0;

  vga_timing_gen_if vif ();
  vga_timing_gen dut (.vga_clk(vga_clk), .reset_n(reset_n), .vga(vif));

  always #20 vga_clk = ~vga_clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: linear raster position within the frame, frame counter, sync history.
  bit         m_started;
  int         m_p;
  int         m_fc;
  logic [1:0] hist[$];

  typedef struct {
    int k;
    int x;
    int y;
    int blank;
    int hs;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(string name, int got, int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] raw_of(int p);
    int x = p % LINE;
    int y = p / LINE;
    return {!(y >= 490 && y < 492), !(x >= 656 && x < 752)};
  endfunction

  task automatic model_reset();
    m_started = 0;
    m_p = 0;
    m_fc = 0;
    hist.delete();
    for (int i = 0; i <= D; i++) hist.push_back(2'b11);
  endtask

  task automatic model_edge();
    if (!m_started) begin
      m_started = 1;
      m_p = 0;
    end else begin
      m_p = (m_p + 1) % FRAME;
    end
    if (m_p == VBL_POS) m_fc = (m_fc + 1) % 65536;
    hist.push_back(raw_of(m_p));
    void'(hist.pop_front());
  endtask

  task automatic check_all();
    int x = m_started ? m_p % LINE : 0;
    int y = m_started ? m_p / LINE : 0;
    chk("DrawX", int'(vif.DrawX), x);
    chk("DrawY", int'(vif.DrawY), y);
    chk("blank", int'(vif.blank), (m_started && x < 640 && y < 480) ? 1 : 0);
    chk("hs", int'(vif.hs), int'(hist[0][0]));
    chk("vs", int'(vif.vs), int'(hist[0][1]));
    chk("vblank_start", int'(vif.vblank_start), (m_started && m_p == VBL_POS) ? 1 : 0);
    chk("frame_count", int'(vif.frame_count), m_fc);
  endtask

  task automatic step();
    @(posedge vga_clk);
    if (reset_n) model_edge();
    @(negedge vga_clk);
    check_all();
  endtask

  // Called at a negedge; releases on the following negedge.
  task automatic do_reset(int hold);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (hold) step();
    reset_n = 1'b1;
  endtask

  // Skip the model and DUT to line y, keeping the current pixel column.
  task automatic jump_to_line(int y);
    force dut.vc_q = coord_t'(y);
    m_p = y * LINE + (m_p % LINE);
    @(posedge vga_clk);
    model_edge();
    #1 release dut.vc_q;
    @(negedge vga_clk);
    check_all();
  endtask

  initial begin
    int blank_cnt, hs_low, hs_fall_x, vs_low, vs_fall_x, vs_fall_y;
    int vbl_cnt, vbl_x, vbl_y, guard;
    logic prev_hs, prev_vs;

    tbl[0] = '{0,    0,   0, 1, 1};
    tbl[1] = '{639,  639, 0, 1, 1};
    tbl[2] = '{640,  640, 0, 0, 1};
    tbl[3] = '{655,  655, 0, 0, 1};
    tbl[4] = '{656,  656, 0, 0, 0};
    tbl[5] = '{751,  751, 0, 0, 0};
    tbl[6] = '{752,  752, 0, 0, 1};
    tbl[7] = '{799,  799, 0, 0, 1};
    tbl[8] = '{800,  0,   1, 1, 1};
    tbl[9] = '{1439, 639, 1, 1, 1};

    model_reset();
    repeat (3) @(negedge vga_clk);
    check_all();

    // Table: cycles counted from the first edge after release.
    foreach (tbl[i]) begin
      do_reset(2);
      repeat (tbl[i].k + 1) step();
      chk("tbl_DrawX", int'(vif.DrawX), tbl[i].x);
      chk("tbl_DrawY", int'(vif.DrawY), tbl[i].y);
      chk("tbl_blank", int'(vif.blank), tbl[i].blank);
      repeat (D) step();
      chk("tbl_hs", int'(vif.hs), tbl[i].hs);
    end

    // First line: blank width, hsync width and falling position.
    do_reset(1);
    blank_cnt = 0; hs_low = 0; hs_fall_x = -1; prev_hs = 1'b1;
    repeat (LINE) begin
      step();
      if (vif.blank) blank_cnt++;
      if (!vif.hs) hs_low++;
      if (prev_hs && !vif.hs) hs_fall_x = int'(vif.DrawX);
      prev_hs = vif.hs;
    end
    chk("line_blank_cycles", blank_cnt, 640);
    chk("line_hs_low_cycles", hs_low, 96);
    chk("line_hs_fall_x", hs_fall_x, 656 + D);
    step();
    chk("line_DrawY_step", int'(vif.DrawY), 1);

    // Vertical blanking entry and vsync.
    jump_to_line(478);
    vs_low = 0; vbl_cnt = 0; vbl_x = -1; vbl_y = -1;
    vs_fall_x = -1; vs_fall_y = -1; prev_vs = 1'b1;
    repeat (17 * LINE) begin
      step();
      if (!vif.vs) vs_low++;
      if (prev_vs && !vif.vs) begin
        vs_fall_x = int'(vif.DrawX);
        vs_fall_y = int'(vif.DrawY);
      end
      prev_vs = vif.vs;
      if (vif.vblank_start) begin
        vbl_cnt++;
        vbl_x = int'(vif.DrawX);
        vbl_y = int'(vif.DrawY);
      end
    end
    chk("vs_low_cycles", vs_low, 1600);
    chk("vs_fall_x", vs_fall_x, D);
    chk("vs_fall_y", vs_fall_y, 490);
    chk("vblank_pulses", vbl_cnt, 1);
    chk("vblank_x", vbl_x, 0);
    chk("vblank_y", vbl_y, 480);
    chk("frame_count_one", int'(vif.frame_count), 1);

    // Simultaneous wrap at (799,524) leaves frame_count alone.
    jump_to_line(523);
    repeat (3 * LINE) step();
    chk("wrap_frame_count", int'(vif.frame_count), 1);

    // Asynchronous reset mid-line at (700,300).
    jump_to_line(300);
    guard = 0;
    while (int'(vif.DrawX) != 700 && guard < 2 * LINE) begin
      step();
      guard++;
    end
    chk("reach_700_300", (int'(vif.DrawX) == 700 && int'(vif.DrawY) == 300) ? 1 : 0, 1);
    reset_n = 1'b0;
    #1;
    chk("async_DrawX", int'(vif.DrawX), 0);
    chk("async_DrawY", int'(vif.DrawY), 0);
    chk("async_blank", int'(vif.blank), 0);
    chk("async_hs", int'(vif.hs), 1);
    chk("async_vs", int'(vif.vs), 1);
    chk("async_vblank", int'(vif.vblank_start), 0);
    chk("async_frame_count", int'(vif.frame_count), 0);
    model_reset();
    @(negedge vga_clk);
    step();
    reset_n = 1'b1;
    step();
    chk("restart_DrawX", int'(vif.DrawX), 0);
    chk("restart_DrawY", int'(vif.DrawY), 0);
    chk("restart_blank", int'(vif.blank), 1);

    // frame_count wraps from 0xFFFF.
    repeat (10) step();
    force dut.fc_q = 16'hFFFF;
    m_fc = 65535;
    @(posedge vga_clk);
    model_edge();
    #1 release dut.fc_q;
    @(negedge vga_clk);
    check_all();
    jump_to_line(479);
    repeat (LINE + 20) step();
    chk("frame_count_wrap", int'(vif.frame_count), 0);

    // Randomised jumps, run lengths and reset interruptions.
    for (int r = 0; r < 6; r++) begin
      jump_to_line(int'($urandom_range(0, 524)));
      repeat ($urandom_range(50, 1500)) step();
      if ($urandom_range(0, 1) == 1) begin
        do_reset(int'($urandom_range(1, 4)));
        repeat ($urandom_range(2, 300)) step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480 @ 60 Hz VGA raster timing from the 25 MHz pixel clock. It is the upstream driver for every sprite/screen mapper: it supplies `DrawX`/`DrawY` and the active-video flag `blank`, and drives the `hs`/`vs` sync pins. An optional sync delay line holds `hs`/`vs` in step with the mappers' ROM-plus-output-register latency. A one-cycle `vblank_start` pulse tells game logic when it may safely update state.

## Interface
- `H_VISIBLE`, 640: active pixels per line
- `H_FP`, 16: horizontal front porch, in pixels
- `H_SYNC`, 96: hsync width, in pixels
- `H_BP`, 48: horizontal back porch, in pixels
- `V_VISIBLE`, 480: active lines per frame
- `V_FP`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vsync width, in lines
- `V_BP`, 33: vertical back porch, in lines
- `PIPE_DELAY`, 2: sync delay in cycles, range 1..4; used only when `VGA_SYNC_DELAY_EN` is defined
- `vga_clk`  in  1  pixel clock; all logic on its rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `DrawX`  out  10  horizontal counter, 0..799
- `DrawY`  out  10  vertical counter, 0..524
- `blank`  out  1  1 = active video (`DrawX` < 640 and `DrawY` < 480); never delayed
- `hs`  out  1  horizontal sync, active low
- `vs`  out  1  vertical sync, active low
- `vblank_start`  out  1  one-cycle pulse on entry to vertical blanking
- `frame_count`  out  16  count of completed frames; wraps

## Operation
**Counters**
- Horizontal counter `hc` increments every cycle.
- At `H_TOTAL`-1 (799), `hc` wraps to 0 and vertical counter `vc` advances.
- At `V_TOTAL`-1 (524), `vc` wraps to 0.
- `H_TOTAL` = sum of the four H parameters; `V_TOTAL` = sum of the four V parameters.
- `DrawX` = `hc` and `DrawY` = `vc`, taken directly from the registers.

**Line phases (combinational decode of `hc`)**
- ACTIVE: 0..639
- FP: 640..655
- SYNC: 656..751, `hs_raw` = 0
- BP: 752..799
- The same four-phase scheme applies to `vc`: sync on lines 490..491.

**Output registers**
- `blank`, `hs_raw` and `vs_raw` are registered, decoded from the next counter values, so they align exactly with the `DrawX`/`DrawY` of the same cycle.
- No combinational path from counters to the sync pins.

**Pulses and counts**
- `vblank_start` = 1 in the cycle where (`hc`,`vc`) = (0,480).
- `frame_count` increments in the same cycle as `vblank_start`.
- Arithmetic: counters are 10 bit unsigned with no overflow. The wrap is an explicit compare, never a natural rollover.
- `frame_count` wraps 0xFFFF → 0x0000.

## Timing
- Reset (asynchronous, any cycle, including mid-line):
  - `hc`, `vc`, `frame_count` = 0
  - `blank` = 0
  - `hs`, `vs` = 1
  - `vblank_start` = 0
  - delay line filled with 1s
- First cycle after release: `DrawX` = 0, `DrawY` = 0, `blank` = 1.
- Frame period: 420 000 cycles. Line period: 800 cycles.
- Simultaneous horizontal and vertical wrap at (799,524): both counters become 0 on the next cycle, and `frame_count` is unaffected at that point.
- `hs` falls at `hc` = 656 and rises at `hc` = 752, offset by the optional delay.
- `vs` transitions at `hc` = 0 of lines 490 and 492.

## Configuration
- `VGA_SYNC_DELAY_EN` defined: `hs` and `vs` pass through a `PIPE_DELAY`-stage shift register. They lag `DrawX`/`DrawY` by exactly `PIPE_DELAY` cycles, matching the mapper pixel latency.
- Not defined: `hs` = `hs_raw` and `vs` = `vs_raw`, with zero added latency. `PIPE_DELAY` is ignored.

## Structure
- Package `vga_pkg`:
  - timing constants `H_TOTAL` and `V_TOTAL`
  - default porch and sync values
  - typedef `coord_t` (logic [9:0])
  - enum `phase_e` {ACTIVE, FP, SYNC, BP}
- Sub-module `vga_delay_line`:
  - parameterised depth
  - asynchronous active-low reset to a parameterised value
  - instantiated once, 2 bits wide, for `hs`/`vs`

## Test plan
- Release reset, then run 800 cycles → `DrawX` goes 0..799 and returns to 0; `DrawY` steps to 1; `blank` = 1 for exactly 640 cycles.
- Check hsync timing without the macro → `hs` = 0 for exactly 96 cycles, starting at `DrawX` = 656.
- Run a full frame (420 000 cycles) → `vs` low for exactly 1600 cycles starting at (0,490); one `vblank_start` pulse at (0,480); `frame_count` = 1.
- With `VGA_SYNC_DELAY_EN` and `PIPE_DELAY` = 2 → `hs` falls when `DrawX` = 658.
- Assert `reset_n` low at (`DrawX`,`DrawY`) = (700,300) → all outputs take their reset values immediately, without waiting for a clock edge; after release, counting restarts from (0,0).
- Preload `frame_count` to 0xFFFF via a force, then let one `vblank_start` occur → `frame_count` = 0x0000.
